dmux8way_sched: RTL

//   Round-robin dispatcher that sequences the 8-way demultiplexer (dmux8way).
//   - Accepts a word from a single valid/ready source and buffers it.
//   - Routes the word to one of 8 sink channels a..h by driving the demux select.
//   - Skips channels that are masked off.
//   - Holds the word until the chosen sink accepts it.

---
 rtl/dmux8way_pkg.sv | 30 +++
 rtl/dmux8way.sv | 24 ++
 rtl/dmux8way_sched.sv | 93 +++++++++
 3 files changed

// File: rtl/dmux8way_pkg.sv
// Shared types and the round-robin channel picker for the dmux8way dispatcher.
package dmux8way_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    // First enabled channel after p, wrapping; p itself is considered last.
    function automatic logic [SEL_W-1:0] rr_next(input logic [N_CH-1:0]  mask,
                                                 input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] idx;
        logic             found;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = p + SEL_W'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer: routes entrada onto the output selected by sel.
module dmux8way (
    input  logic       entrada,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);

    assign a = entrada & (sel == 3'd0);
    assign b = entrada & (sel == 3'd1);
    assign c = entrada & (sel == 3'd2);
    assign d = entrada & (sel == 3'd3);
    assign e = entrada & (sel == 3'd4);
    assign f = entrada & (sel == 3'd5);
    assign g = entrada & (sel == 3'd6);
    assign h = entrada & (sel == 3'd7);

endmodule

// File: rtl/dmux8way_sched.sv
// Round-robin dispatcher: buffers one source word and drives dmux8way to hand it
// to the next enabled sink channel, holding it until that sink accepts.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no word held; entrada=0, in_ready follows en_mask
//   ST_BUSY | word held in out_data on channel sel; entrada=1
module dmux8way_sched
    import dmux8way_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]   en_mask,
    output logic [SEL_W-1:0]  sel,
    output logic              entrada,
    output logic [N_CH-1:0]   out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [N_CH-1:0]   out_ready,
    output logic [CNT_W-1:0]  disp_cnt
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fire;
    logic                capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd7;
            sel_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fire     = (state_q == ST_BUSY) && out_ready[sel_q];
    assign in_ready = (en_mask != '0) && ((state_q == ST_IDLE) || fire);
    assign capture  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (fire) begin
            ptr_d   = sel_q;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_IDLE;
        end
        // While busy a capture only happens alongside fire, so sel_q is the new ptr.
        if (capture) begin
            data_d  = in_data;
            sel_d   = rr_next(en_mask, (state_q == ST_BUSY) ? sel_q : ptr_q);
            state_d = ST_BUSY;
        end
    end

    assign entrada  = (state_q == ST_BUSY);
    assign sel      = sel_q;
    assign out_data = data_q;
    assign disp_cnt = cnt_q;

    dmux8way u_dmux (
        .entrada (entrada),
        .sel     (sel_q),
        .a       (out_valid[0]),
        .b       (out_valid[1]),
        .c       (out_valid[2]),
        .d       (out_valid[3]),
        .e       (out_valid[4]),
        .f       (out_valid[5]),
        .g       (out_valid[6]),
        .h       (out_valid[7])
    );

endmodule
